// File: rtl/mux_n_pipe.sv
// N-to-1 valid/ready multiplexer with a single registered output stage.
// Optional round-robin arbitration is built when MUX_N_PIPE_RR_EN is defined.
module mux_n_pipe #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      rr_mode,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      dbg_state
);

   // Handshake: a word moves on any channel or on the output only in a cycle
   // where both valid and ready are high at the rising edge; valid never
   // waits on ready, and ready is one-hot or zero across the input channels.

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

   state_t             state_q, state_d;
   logic               accept_en;
   logic               chosen_vld;
   logic [SEL_W-1:0]   chosen_idx;
   logic [WIDTH-1:0]   chosen_data;
   logic               xfer;

   function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= CHANNELS) s = s - CHANNELS;
      return s[SEL_W-1:0];
   endfunction

`ifdef MUX_N_PIPE_RR_EN
   logic [SEL_W-1:0]    ptr_q;
   logic [CHANNELS-1:0] rot_valid;
   int                  rr_off;
   logic                rr_any;

   // Rotating the valid vector by ptr turns the wrap-around scan into a
   // plain lowest-index priority pick.
   always_comb begin
      rot_valid = CHANNELS'({in_valid, in_valid} >> ptr_q);
      rr_off    = 0;
      rr_any    = 1'b0;
      for (int k = CHANNELS-1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            rr_off = k;
            rr_any = 1'b1;
         end
      end
   end
`else
   logic rr_unused;
   assign rr_unused = rr_mode;
`endif

   always_comb begin
      chosen_vld = 1'b0;
      chosen_idx = '0;
      if ({1'b0, sel} < CH_LIMIT) begin
         chosen_vld = 1'b1;
         chosen_idx = sel;
      end
`ifdef MUX_N_PIPE_RR_EN
      if (rr_mode) begin
         chosen_vld = rr_any;
         chosen_idx = wrap_add(ptr_q, rr_off);
      end
`endif
   end

   assign accept_en = (state_q == S_EMPTY) || out_ready;

   always_comb begin
      in_ready    = '0;
      chosen_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = rst_n && accept_en && chosen_vld && (chosen_idx == SEL_W'(i));
         if (chosen_idx == SEL_W'(i)) chosen_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (xfer) state_d = S_FULL;
         S_FULL:  if (out_ready && !xfer) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_EMPTY;
         out_data <= '0;
         out_chan <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            out_data <= chosen_data;
            out_chan <= chosen_idx;
         end
      end
   end

`ifdef MUX_N_PIPE_RR_EN
   // ptr only advances on a round-robin grant; explicit traffic leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (rr_mode && xfer) begin
         ptr_q <= wrap_add(chosen_idx, 1);
      end
   end
`endif

   assign out_valid = (state_q == S_FULL);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: expected words go into a queue, a monitor
// pops them as the output handshakes; round-robin checks need MUX_N_PIPE_RR_EN.
module tb_mux_n_pipe;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int SW = 2;

   logic          clk;
   logic          rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [SW-1:0] sel;
   logic          rr_mode;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_chan;
   logic          out_valid;
   logic          out_ready;
   logic          dbg_state;

   logic [3*W-1:0] in_data3;
   logic [2:0]    in_valid3;
   logic [2:0]    in_ready3;
   logic [SW-1:0] sel3;
   logic          rr_mode3;
   logic [W-1:0]  out_data3;
   logic [SW-1:0] out_chan3;
   logic          out_valid3;
   logic          out_ready3;
   logic          dbg_state3;

   int checks   = 0;
   int failures = 0;
   logic [SW+W-1:0] exp_q[$];

   mux_n_pipe #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
      .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
      .dbg_state(dbg_state)
   );

   mux_n_pipe #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .sel(sel3), .rr_mode(rr_mode3), .out_data(out_data3),
      .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3),
      .dbg_state(dbg_state3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [W-1:0] d);
      in_data[c*W +: W] = d;
   endtask

   task automatic push(input logic [SW-1:0] c, input logic [W-1:0] d);
      exp_q.push_back({c, d});
   endtask

   // monitor: every output handshake must match the head of the queue
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual=%0h/%0h expected=none", out_chan, out_data);
         end else begin
            logic [SW+W-1:0] e;
            e = exp_q.pop_front();
            if ({out_chan, out_data} !== e) begin
               failures++;
               $display("FAIL sb_word actual=%0h/%0h expected=%0h/%0h",
                        out_chan, out_data, e[SW+W-1:W], e[W-1:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = 4'b1111; sel = 2'd0; rr_mode = 1'b0;
      out_ready = 1'b1;
      in_data3 = '0; in_valid3 = 3'b000; sel3 = 2'd0; rr_mode3 = 1'b0; out_ready3 = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_chan", out_chan, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_dbg_state", dbg_state, 0);
      in_valid = '0;
      step();
      rst_n = 1'b1;
      step();

      // single word on ch2
      sel = 2'd2; set_ch(2, 32'h0000000A); in_valid = 4'b0100; out_ready = 1'b1;
      #1 chk("basic_in_ready", in_ready, 4'b0100);
      push(2'd2, 32'h0000000A);
      step();
      in_valid = '0;
      chk("basic_out_valid", out_valid, 1);
      chk("basic_out_data", out_data, 32'hA);
      chk("basic_out_chan", out_chan, 2);
      chk("basic_dbg_state", dbg_state, 1);
      step();
      chk("basic_drained", out_valid, 0);

      // stall: hold 0xA for 5 cycles while 0xB waits
      out_ready = 1'b0; set_ch(2, 32'h0000000A); in_valid = 4'b0100;
      #1 chk("stall_load_ready", in_ready, 4'b0100);
      push(2'd2, 32'h0000000A);
      step();
      set_ch(2, 32'h0000000B);
      for (int i = 0; i < 5; i++) begin
         #1 chk("stall_in_ready", in_ready, 0);
         chk("stall_out_data", out_data, 32'hA);
         chk("stall_out_valid", out_valid, 1);
         step();
      end
      out_ready = 1'b1;
      #1 chk("stall_release_ready", in_ready, 4'b0100);
      push(2'd2, 32'h0000000B);
      step();
      in_valid = '0;
      chk("stall_new_word", out_data, 32'hB);
      chk("stall_new_valid", out_valid, 1);
      step();

      // stream ch1 words 1..8 at full rate
      sel = 2'd1;
      for (int k = 1; k <= 8; k++) begin
         set_ch(1, W'(k)); in_valid = 4'b0010;
         #1 chk("stream_in_ready", in_ready, 4'b0010);
         push(2'd1, W'(k));
         if (k > 1) begin
            chk("stream_out_valid", out_valid, 1);
            chk("stream_out_data", out_data, W'(k-1));
            chk("stream_out_chan", out_chan, 1);
         end
         step();
      end
      in_valid = '0;
      chk("stream_last", out_data, 32'h8);

      // explicit select follows sel combinationally, independent of in_valid
      sel = 2'd3; in_valid = 4'b0100;
      #1 chk("sel_change_ready", in_ready, 4'b1000);
      step();
      chk("sel_no_xfer", out_valid, 0);
      in_valid = '0;

`ifdef MUX_N_PIPE_RR_EN
      rr_mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_ch(k % 4, 32'h100 + k); in_valid = 4'b1111;
         #1 chk("rr_all_ready", in_ready, 4'b0001 << (k % 4));
         push(2'(k % 4), 32'h100 + k);
         step();
      end
      begin
         logic [1:0] seq[4];
         seq = '{2'd1, 2'd3, 2'd1, 2'd3};
         for (int k = 0; k < 4; k++) begin
            set_ch(seq[k], 32'h200 + k); in_valid = 4'b1010;
            #1 chk("rr_sparse_ready", in_ready, 4'b0001 << seq[k]);
            push(seq[k], 32'h200 + k);
            step();
         end
      end
      in_valid = '0;
      #1 chk("rr_idle_ready", in_ready, 0);
      step();
`else
      rr_mode = 1'b1; sel = 2'd0; in_valid = 4'b1010;
      #1 chk("rr_ignored_ready", in_ready, 4'b0001);
      step();
      chk("rr_ignored_no_xfer", out_valid, 0);
      in_valid = '0;
      rr_mode = 1'b0;
`endif

      // CHANNELS=3 instance: out-of-range select
      sel3 = 2'd3; in_valid3 = 3'b111;
      #1 chk("oor_in_ready", in_ready3, 3'b000);
      step();
      chk("oor_out_valid", out_valid3, 0);
      sel3 = 2'd2; in_data3[2*W +: W] = 32'h33;
      #1 chk("ch3_in_ready", in_ready3, 3'b100);
      step();
      in_valid3 = '0;
      chk("ch3_out_chan", out_chan3, 2);
      chk("ch3_out_data", out_data3, 32'h33);

      // reset mid-stream with a held word (grant on ch2 moves ptr off zero)
      sel = 2'd2; set_ch(2, 32'h55); in_valid = 4'b0100; out_ready = 1'b0;
      step();
      in_valid = '0;
      chk("pre_rst_data", out_data, 32'h55);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_chan", out_chan, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
`ifdef MUX_N_PIPE_RR_EN
      set_ch(0, 32'h66); in_valid = 4'b1111;
      #1 chk("post_rst_rr_ready", in_ready, 4'b0001);
      push(2'd0, 32'h66);
`else
      sel = 2'd3; set_ch(3, 32'h66); in_valid = 4'b1000;
      #1 chk("post_rst_ready", in_ready, 4'b1000);
      push(2'd3, 32'h66);
`endif
      step();
      in_valid = '0;
      chk("post_rst_valid", out_valid, 1);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      chk("drain_queue", exp_q.size(), 0);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
